// File: rtl/hstx_lane_ctrl_if.sv
// PPI-style HS transmit handshake between the protocol layer and the lane sequencer.
// Latency: none (wires only).
// Backpressure: the sequencer raises TxReadyHS only while it is in the data state.
//
// Ports:
//   TxRequestHS  burst request / data valid from the protocol layer
//   TxDataHS     lane k byte at bits [8k+7:8k]
//   TxReadyHS    sequencer ready for bytes
interface hstx_lane_ctrl_if #(
    parameter int NUM_LANES = 4
);
    logic                   TxRequestHS;
    logic [8*NUM_LANES-1:0] TxDataHS;
    logic                   TxReadyHS;

    modport master (
        output TxRequestHS,
        output TxDataHS,
        input  TxReadyHS
    );

    modport slave (
        input  TxRequestHS,
        input  TxDataHS,
        output TxReadyHS
    );
endinterface

// File: rtl/hstx_lane_ctrl.sv
// Multi-lane D-PHY HS-TX burst sequencer: LP-00 prepare, HS-zero, sync, data, trail, exit.
// Latency: outputs are registered from the next state, so they describe the current state.
// Backpressure: TxReadyHS is high only in DATA; dropping TxRequestHS there ends the burst.
//
// Ports:
//   TxDDRClkHS / TxRst_n        byte clock, async active-low reset
//   ppi (slave)                 TxRequestHS / TxDataHS in, TxReadyHS out
//   ActiveLanes, Hs*Time        burst configuration, latched when a request leaves STOP
//   HsBytes, LaneHsEn, Lp00En   per-lane serialiser bytes and driver enables
//   TxState, HsBusy             current sequencer state, busy flag
module hstx_lane_ctrl #(
    parameter int         NUM_LANES   = 4,
    parameter int         CNT_W       = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hB8,
    parameter logic [7:0] HSEXIT_TIME = 8'h08
) (
    input  logic                   TxDDRClkHS,
    input  logic                   TxRst_n,
    hstx_lane_ctrl_if.slave        ppi,
    input  logic [1:0]             ActiveLanes,
    input  logic [CNT_W-1:0]       HsPrepareTime,
    input  logic [CNT_W-1:0]       HsZeroTime,
    input  logic [CNT_W-1:0]       HsTrailTime,
    output logic [8*NUM_LANES-1:0] HsBytes,
    output logic [NUM_LANES-1:0]   LaneHsEn,
    output logic                   Lp00En,
    output logic [2:0]             TxState,
    output logic                   HsBusy
);

    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_PREPARE = 3'd1,
        ST_ZERO    = 3'd2,
        ST_SYNC    = 3'd3,
        ST_DATA    = 3'd4,
        ST_TRAIL   = 3'd5,
        ST_EXIT    = 3'd6
    } state_e;

    localparam logic [1:0]       MAX_LANE  = 2'(NUM_LANES - 1);
    localparam int               EXIT_CYC  = (HSEXIT_TIME == 8'h00) ? 1 : int'(HSEXIT_TIME);
    localparam logic [CNT_W-1:0] EXIT_LAST = CNT_W'(EXIT_CYC - 1);

    // A state lasting N cycles leaves when the in-state counter reaches N-1;
    // a programmed time of 0 behaves like 1.
    function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]       prep_last_q, prep_last_d;
    logic [CNT_W-1:0]       zero_last_q, zero_last_d;
    logic [CNT_W-1:0]       trail_last_q, trail_last_d;
    logic [NUM_LANES-1:0]   lastbit_q, lastbit_d;
    logic [8*NUM_LANES-1:0] hs_bytes_q, hs_bytes_d;
    logic [NUM_LANES-1:0]   lane_en_q, lane_en_d;
    logic                   lp00_q, lp00_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;

    logic [1:0]             act_clamped;
    logic [NUM_LANES-1:0]   req_mask;
    logic [8*NUM_LANES-1:0] data_masked;
    logic                   data_ld;

    always_comb begin
        act_clamped = (ActiveLanes > MAX_LANE) ? MAX_LANE : ActiveLanes;
        req_mask    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            req_mask[k] = (2'(k) <= act_clamped);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        mask_d       = mask_q;
        prep_last_d  = prep_last_q;
        zero_last_d  = zero_last_q;
        trail_last_d = trail_last_q;
        lastbit_d    = lastbit_q;
        data_ld      = 1'b0;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (ppi.TxRequestHS) begin
                    state_d      = ST_PREPARE;
                    mask_d       = req_mask;
                    prep_last_d  = last_idx(HsPrepareTime);
                    zero_last_d  = last_idx(HsZeroTime);
                    trail_last_d = last_idx(HsTrailTime);
                    // With no byte accepted the trail inverts the sync byte's last bit.
                    lastbit_d    = {NUM_LANES{SYNC_BYTE[7]}};
                end
            end
            ST_PREPARE: begin
                if (cnt_q == prep_last_q) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end
            end
            ST_ZERO: begin
                if (cnt_q == zero_last_q) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                // The edge that enters DATA already takes the first byte, so the
                // byte shows on HsBytes during the DATA cycle that TxReadyHS marks.
                state_d = ST_DATA;
                cnt_d   = '0;
                data_ld = ppi.TxRequestHS;
            end
            ST_DATA: begin
                cnt_d = '0;
                if (ppi.TxRequestHS) begin
                    data_ld = 1'b1;
                end else begin
                    state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (cnt_q == trail_last_q) begin
                    state_d = ST_EXIT;
                    cnt_d   = '0;
                end
            end
            ST_EXIT: begin
                if (cnt_q == EXIT_LAST) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase

        data_masked = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (mask_d[k]) begin
                data_masked[8*k +: 8] = ppi.TxDataHS[8*k +: 8];
            end
            if (data_ld) begin
                lastbit_d[k] = ppi.TxDataHS[8*k+7];
            end
        end

        // Output decode from the next state; inactive lanes stay at zero.
        hs_bytes_d = '0;
        lane_en_d  = '0;
        lp00_d     = 1'b0;
        ready_d    = 1'b0;
        case (state_d)
            ST_PREPARE: begin
                lp00_d = 1'b1;
            end
            ST_ZERO: begin
                lane_en_d = mask_d;
            end
            ST_SYNC: begin
                lane_en_d = mask_d;
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (mask_d[k]) begin
                        hs_bytes_d[8*k +: 8] = SYNC_BYTE;
                    end
                end
            end
            ST_DATA: begin
                lane_en_d  = mask_d;
                ready_d    = 1'b1;
                hs_bytes_d = data_ld ? data_masked : hs_bytes_q;
            end
            ST_TRAIL: begin
                lane_en_d = mask_d;
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (mask_d[k]) begin
                        hs_bytes_d[8*k +: 8] = {8{~lastbit_d[k]}};
                    end
                end
            end
            default: begin
            end
        endcase
        busy_d = (state_d != ST_STOP);
    end

    always_ff @(posedge TxDDRClkHS or negedge TxRst_n) begin
        if (!TxRst_n) begin
            state_q      <= ST_STOP;
            cnt_q        <= '0;
            mask_q       <= '0;
            prep_last_q  <= '0;
            zero_last_q  <= '0;
            trail_last_q <= '0;
            lastbit_q    <= '0;
            hs_bytes_q   <= '0;
            lane_en_q    <= '0;
            lp00_q       <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            prep_last_q  <= prep_last_d;
            zero_last_q  <= zero_last_d;
            trail_last_q <= trail_last_d;
            lastbit_q    <= lastbit_d;
            hs_bytes_q   <= hs_bytes_d;
            lane_en_q    <= lane_en_d;
            lp00_q       <= lp00_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign ppi.TxReadyHS = ready_q;
    assign HsBytes       = hs_bytes_q;
    assign LaneHsEn      = lane_en_q;
    assign Lp00En        = lp00_q;
    assign TxState       = state_q;
    assign HsBusy        = busy_q;

endmodule

// File: tb/tb_hstx_lane_ctrl.sv
// Directed bench for hstx_lane_ctrl: burst sequencing, lane masking, zero times,
// early drop, async reset mid-burst and mid-burst config changes.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_hstx_lane_ctrl;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  act = 2'd0;
    logic [7:0]  prep = 8'd0;
    logic [7:0]  zero = 8'd0;
    logic [7:0]  trail = 8'd0;
    logic [31:0] hs_bytes;
    logic [3:0]  lane_en;
    logic        lp00;
    logic [2:0]  st;
    logic        busy;

    always #5 clk = ~clk;

    hstx_lane_ctrl_if #(.NUM_LANES(NL)) ppi ();

    hstx_lane_ctrl #(.NUM_LANES(NL)) dut (
        .TxDDRClkHS    (clk),
        .TxRst_n       (rst_n),
        .ppi           (ppi.slave),
        .ActiveLanes   (act),
        .HsPrepareTime (prep),
        .HsZeroTime    (zero),
        .HsTrailTime   (trail),
        .HsBytes       (hs_bytes),
        .LaneHsEn      (lane_en),
        .Lp00En        (lp00),
        .TxState       (st),
        .HsBusy        (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_st"},    32'(st),            32'd0);
        check({tag, "_bytes"}, hs_bytes,           32'd0);
        check({tag, "_en"},    32'(lane_en),       32'd0);
        check({tag, "_lp00"},  32'(lp00),          32'd0);
        check({tag, "_rdy"},   32'(ppi.TxReadyHS), 32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
    endtask

    // Per-burst observations filled by burst().
    int          dur [8];
    int          rdy_cnt;
    logic [3:0]  en_or, en_and;
    logic [31:0] bytes_or;
    logic [31:0] trail_bytes;

    // Starts a burst from STOP, keeps TxRequestHS high on the edges that load
    // nbytes beats of w, and runs until the sequencer is back in STOP.
    task automatic burst(input int nbytes, input logic [31:0] w, input logic [7:0] trail_mid);
        int loaded;
        int s;
        bit done;
        bit got_trail;
        for (int i = 0; i < 8; i++) dur[i] = 0;
        rdy_cnt     = 0;
        en_or       = '0;
        en_and      = '1;
        bytes_or    = '0;
        trail_bytes = '0;
        got_trail   = 1'b0;
        loaded      = 0;
        done        = 1'b0;
        ppi.TxRequestHS = 1'b1;
        ppi.TxDataHS    = w;
        for (int c = 0; c < 600 && !done; c++) begin
            @(posedge clk);
            #1;
            s = int'(st);
            dur[s]++;
            rdy_cnt += int'(ppi.TxReadyHS);
            if (s >= 2 && s <= 5) begin
                en_or  |= lane_en;
                en_and &= lane_en;
            end
            bytes_or |= hs_bytes;
            if (s == 5 && !got_trail) begin
                trail_bytes = hs_bytes;
                got_trail   = 1'b1;
            end
            if (s == 2) trail = trail_mid;
            if (s == 0) done = 1'b1;
            if (s == 3 || s == 4) begin
                if (loaded < nbytes) begin
                    ppi.TxRequestHS = 1'b1;
                    loaded++;
                end else begin
                    ppi.TxRequestHS = 1'b0;
                end
            end else if (s == 1 || s == 2) begin
                ppi.TxRequestHS = (nbytes > 0);
            end else begin
                ppi.TxRequestHS = 1'b0;
            end
        end
        ppi.TxRequestHS = 1'b0;
        check("burst_back_to_stop", 32'(done), 32'd1);
    endtask

    localparam logic [31:0] W0 = 32'hA1_70_33_11;
    localparam logic [31:0] W1 = 32'h02_5F_44_22;
    localparam logic [31:0] W2 = 32'hC3_01_7E_83;
    localparam logic [31:0] SY = 32'hB8_B8_B8_B8;
    localparam logic [31:0] TR = 32'h00_FF_FF_00;

    int          exp_st [20] = '{1,1,2,2,2,3,4,4,4,5,5,6,6,6,6,6,6,6,6,0};
    logic [31:0] exp_by [20] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, SY, W0, W1, W2, TR, TR,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        bit reached;
        ppi.TxRequestHS = 1'b0;
        ppi.TxDataHS    = '0;

        // Reset state
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_st", 32'(st), 32'd0);

        // Basic 4-lane burst, cycle by cycle
        act = 2'd3; prep = 8'd2; zero = 8'd3; trail = 8'd2;
        ppi.TxDataHS    = W0;
        ppi.TxRequestHS = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("basic_st[%0d]", i),    32'(st),       32'(exp_st[i]));
            check($sformatf("basic_bytes[%0d]", i), hs_bytes,      exp_by[i]);
            check($sformatf("basic_en[%0d]", i),    32'(lane_en),  (i >= 2 && i <= 10) ? 32'hF : 32'h0);
            check($sformatf("basic_lp00[%0d]", i),  32'(lp00),     (i <= 1) ? 32'd1 : 32'd0);
            check($sformatf("basic_busy[%0d]", i),  32'(busy),     (i < 19) ? 32'd1 : 32'd0);
            rdy_cnt += int'(ppi.TxReadyHS);
            if (i == 6) ppi.TxDataHS = W1;
            if (i == 7) ppi.TxDataHS = W2;
            if (i == 8) ppi.TxRequestHS = 1'b0;
        end
        check("basic_ready_cycles", 32'(rdy_cnt), 32'd3);

        // Single active lane; lanes 1-3 carry FF that must never appear
        act = 2'd0; prep = 8'd1; zero = 8'd2; trail = 8'd3;
        burst(2, 32'hFF_FF_FF_5A, 8'd3);
        check("single_en_or",   32'(en_or),    32'h1);
        check("single_en_and",  32'(en_and),   32'h1);
        check("single_upper",   bytes_or & 32'hFFFF_FF00, 32'h0);
        check("single_trail",   trail_bytes,   32'h0000_00FF);
        check("single_zero",    32'(dur[2]),   32'd2);
        check("single_data",    32'(dur[4]),   32'd2);
        check("single_trail_n", 32'(dur[5]),   32'd3);
        check("single_exit_n",  32'(dur[6]),   32'd8);

        // Zero times behave like one cycle
        act = 2'd1; prep = 8'd0; zero = 8'd0; trail = 8'd0;
        burst(1, 32'h12_34_56_78, 8'd0);
        check("zt_prep",   32'(dur[1]),  32'd1);
        check("zt_zero",   32'(dur[2]),  32'd1);
        check("zt_sync",   32'(dur[3]),  32'd1);
        check("zt_trail",  32'(dur[5]),  32'd1);
        check("zt_en",     32'(en_or),   32'h3);
        check("zt_tbytes", trail_bytes,  32'h0000_FFFF);

        // Early drop: one-cycle request pulse, no byte accepted
        act = 2'd3; prep = 8'd2; zero = 8'd1; trail = 8'd2;
        burst(0, 32'hFF_FF_FF_FF, 8'd2);
        check("drop_prep",   32'(dur[1]),  32'd2);
        check("drop_zero",   32'(dur[2]),  32'd1);
        check("drop_data",   32'(dur[4]),  32'd1);
        check("drop_rdy",    32'(rdy_cnt), 32'd1);
        check("drop_trail",  32'(dur[5]),  32'd2);
        check("drop_tbytes", trail_bytes,  32'h0);
        check("drop_en",     32'(en_and),  32'hF);

        // Config change mid-burst: trail 2 -> 9 during ZERO
        act = 2'd3; prep = 8'd1; zero = 8'd4; trail = 8'd2;
        burst(2, W1, 8'd9);
        check("cfg_trail_now",  32'(dur[5]), 32'd2);
        burst(2, W1, 8'd9);
        check("cfg_trail_next", 32'(dur[5]), 32'd9);

        // Reset asserted between edges during DATA
        act = 2'd3; prep = 8'd1; zero = 8'd1; trail = 8'd1;
        ppi.TxDataHS    = W2;
        ppi.TxRequestHS = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(posedge clk);
            #1;
            if (st == 3'd4) reached = 1'b1;
        end
        check("rst_reached_data", 32'(reached), 32'd1);
        check("rst_pre_bytes",    hs_bytes,     W2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        ppi.TxRequestHS = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after_st", 32'(st), 32'd0);
        ppi.TxRequestHS = 1'b1;
        @(posedge clk);
        #1;
        check("rst_restart_st",   32'(st),   32'd1);
        check("rst_restart_lp00", 32'(lp00), 32'd1);
        ppi.TxRequestHS = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(posedge clk);
            #1;
            if (st == 3'd0) reached = 1'b1;
        end
        check("rst_restart_done", 32'(reached), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/hstx_lane_ctrl.md
Name: hstx_lane_ctrl

Overview:
Multi-lane high-speed transmit sequencer for the MIPI D-PHY TX datapath.
- Runs the full HS burst on NUM_LANES data lanes: LP-00 prepare, HS-zero, sync, data, trail, exit.
- Accepts parallel per-lane bytes through a PPI-style TxRequestHS/TxReadyHS handshake.
- Drives per-lane bytes and enables to the serialisers.
- Generalises the single-lane HS-TX FSM with runtime timing values, an active-lane count, proper inverted trail and an exit state.

Parameters:
NUM_LANES, 4, number of physical data lanes (1..4)
CNT_W, 8, width of timing counters and timing inputs
SYNC_BYTE, 8'hB8, leader sequence byte sent on every active lane
HSEXIT_TIME, 8'h08, cycles spent in EXIT before returning to STOP (0 treated as 1)

Ports:
TxDDRClkHS  input  1  byte clock; all state changes on rising edge
TxRst_n  input  1  asynchronous active-low reset
TxRequestHS  input  1  burst request / data valid from protocol layer
TxDataHS  input  8*NUM_LANES  lane k byte at bits [8k+7:8k]
ActiveLanes  input  2  number of active lanes minus 1; sampled at request
HsPrepareTime  input  CNT_W  prepare cycles; sampled at request
HsZeroTime  input  CNT_W  HS-zero cycles; sampled at request
HsTrailTime  input  CNT_W  trail cycles; sampled at request
TxReadyHS  output  1  byte accepted when high together with TxRequestHS
HsBytes  output  8*NUM_LANES  bytes to the per-lane serialisers
LaneHsEn  output  NUM_LANES  per-lane HS driver enable
Lp00En  output  1  drive LP-00 on active lanes (prepare)
TxState  output  3  0 STOP, 1 PREPARE, 2 ZERO, 3 SYNC, 4 DATA, 5 TRAIL, 6 EXIT
HsBusy  output  1  high whenever state is not STOP

Behaviour:
- Reset (async assert, sync release): state STOP; HsBytes 0, LaneHsEn 0, Lp00En 0, TxReadyHS 0, TxState 0, HsBusy 0; counters and latched config cleared.
- All outputs are registered and decoded from next_state, so they are valid in the same cycle as the state they describe.
- Timing counters count cycles within a state. A latched time value of 0 is treated as 1. A state with time N lasts exactly N cycles.
- STOP: when TxRequestHS=1 is sampled, latch ActiveLanes and the three times, then go to PREPARE. Otherwise stay in STOP.
- PREPARE: Lp00En=1, LaneHsEn=0, HsBytes=0. After HsPrepareTime cycles go to ZERO.
- ZERO: LaneHsEn[k]=1 for k<=ActiveLanes, Lp00En=0, active-lane bytes 8'h00. After HsZeroTime cycles go to SYNC.
- SYNC: exactly 1 cycle; each active lane byte = SYNC_BYTE; then go to DATA.
- DATA: TxReadyHS=1.
  - Each edge with TxRequestHS=1: active-lane HsBytes <= TxDataHS lane bytes, and lastbit[k] <= TxDataHS[8k+7].
  - TxRequestHS=0: the byte is not accepted; go to TRAIL and TxReadyHS drops in the same cycle.
- TRAIL: each active lane drives {8{~lastbit[k]}} for HsTrailTime cycles; TxReadyHS=0. Then go to EXIT.
  - If no byte was accepted, lastbit[k] = SYNC_BYTE[7].
- EXIT: LaneHsEn=0, HsBytes=0 for HSEXIT_TIME cycles; TxRequestHS ignored. Then go to STOP.
- Inactive lanes (k>ActiveLanes): HsBytes lane = 0 and LaneHsEn[k] = 0 in every state.
- Config inputs changing mid-burst have no effect until the next STOP sampling.
- TxRequestHS dropping during PREPARE, ZERO or SYNC is ignored. The sequence reaches DATA, sees TxRequestHS low, and goes directly to TRAIL with zero bytes accepted.
- ActiveLanes >= NUM_LANES is clamped to NUM_LANES-1.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronously); the partial burst is abandoned.
- Unused state encodings: go to STOP next cycle with outputs at reset values.

Test Plan:
- Basic 4-lane burst:
  - Stimulus: prep=2, zero=3, trail=2, ActiveLanes=3; TxRequestHS high for 3 data bytes per lane, lane0 bytes 11,22,83.
  - Required: TxState sequence 1,1,2,2,2,3,4,4,4,5,5,6×8,0; lane0 HsBytes 00,00,00,B8,11,22,83,00,00 (trail = ~1); TxReadyHS high for exactly 3 cycles.
- Single active lane:
  - Stimulus: ActiveLanes=0, lanes1-3 TxDataHS = FF.
  - Required: LaneHsEn=4'b0001 throughout ZERO..TRAIL; lanes1-3 HsBytes remain 00.
- Zero times:
  - Stimulus: prep=zero=trail=0.
  - Required: each of PREPARE, ZERO and TRAIL lasts exactly 1 cycle.
- Early drop:
  - Stimulus: TxRequestHS pulse of 1 cycle in STOP, then low.
  - Required: full preamble runs; DATA lasts 1 cycle with no byte accepted; trail bytes = {8{~SYNC_BYTE[7]}} = 00.
- Reset during burst:
  - Stimulus: TxRst_n low during DATA (mid-cycle, between edges).
  - Required: all outputs 0 immediately (no clock edge needed); after release, TxState=0 and a new request starts from PREPARE.
- Config change mid-burst:
  - Stimulus: HsTrailTime changed from 2 to 9 during ZERO.
  - Required: TRAIL lasts 2 cycles; the next burst uses 9.
